// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester ports, the shared-ALU operand/result port and the
// response port of alu_arbiter; slave is the arbiter side, master the environment.
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [5:0]  req0_func;

  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [5:0]  req1_func;

  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [5:0]  alu_func;
  logic [31:0] alu_out;
  logic        alu_zero;

  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_zero;

  logic        busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_func,
    input  req1_valid, req1_a, req1_b, req1_func,
    input  alu_out, alu_zero, rsp_ready,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_func,
    output rsp_valid, rsp_id, rsp_data, rsp_zero, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_func,
    output req1_valid, req1_a, req1_b, req1_func,
    output alu_out, alu_zero, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_func,
    input  rsp_valid, rsp_id, rsp_data, rsp_zero, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one clocked ALU between two requesters; one
// operation in flight, result held until the response handshake completes.
module alu_arbiter #(
  parameter int ALU_LAT = 1
) (
  input logic         clk,
  input logic         rst_n,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT4 = 4'(ALU_LAT);

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg;
  logic        last_reg;
  logic        id_reg;
  logic [31:0] data_reg;
  logic        zero_reg;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [5:0]  func_reg;

  logic grant_id;
  logic grant_any;
  logic ready0;
  logic ready1;
  logic accept;

  // On a tie the requester that did not win last time gets the grant.
  assign grant_id  = (bus.req0_valid && bus.req1_valid) ? ~last_reg : bus.req1_valid;
  assign grant_any = bus.req0_valid | bus.req1_valid;
  assign ready0    = rst_n && (state_reg == IDLE) && grant_any && !grant_id;
  assign ready1    = rst_n && (state_reg == IDLE) && grant_any && grant_id;
  assign accept    = ready0 | ready1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (cnt_reg <= 4'd1) state_next = RESP;
      RESP:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.req0_ready = ready0;
    bus.req1_ready = ready1;
    bus.busy       = (state_reg != IDLE);
    bus.rsp_valid  = (state_reg == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg  <= 4'd0;
      last_reg <= 1'b1;
      id_reg   <= 1'b0;
      data_reg <= 32'd0;
      zero_reg <= 1'b0;
      a_reg    <= 32'd0;
      b_reg    <= 32'd0;
      func_reg <= 6'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            a_reg    <= grant_id ? bus.req1_a    : bus.req0_a;
            b_reg    <= grant_id ? bus.req1_b    : bus.req0_b;
            func_reg <= grant_id ? bus.req1_func : bus.req0_func;
            id_reg   <= grant_id;
            last_reg <= grant_id;
          end
        end
        ISSUE: cnt_reg <= LAT4;
        WAIT: begin
          // The edge that takes the counter to zero is the one where the ALU result is valid.
          cnt_reg <= (cnt_reg <= 4'd1) ? 4'd0 : cnt_reg - 4'd1;
          if (cnt_reg <= 4'd1) begin
            data_reg <= bus.alu_out;
            zero_reg <= bus.alu_zero;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.alu_a    = a_reg;
  assign bus.alu_b    = b_reg;
  assign bus.alu_func = func_reg;
  assign bus.rsp_id   = id_reg;
  assign bus.rsp_data = data_reg;
  assign bus.rsp_zero = zero_reg;
endmodule
